// File: rtl/eth_pkg.sv
// Shared PHY1 Ethernet definitions: receive FSM states, framing and CRC32 constants,
// and the byte-wide reflected CRC32 step that the transmit FCS generator also uses.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_CHECK,
    ST_DROP
  } rcv_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_mac_filter.sv
// Destination MAC filter: accumulates a per-byte match against the station and
// broadcast addresses over bytes 0..5; hit is meaningful when idx == 5 and en is high.
module eth_mac_filter
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter bit          PROMISC  = 1'b0
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] idx,
  input  logic [7:0] data,
  output logic       hit
);

  logic       mac_ok_q, mac_ok_d;
  logic       bc_ok_q, bc_ok_d;
  logic [7:0] mac_byte;
  logic [7:0] bc_byte;

  always_comb begin
    case (idx)
      3'd0:    begin mac_byte = MAC_ADDR[47:40]; bc_byte = BCAST_MAC[47:40]; end
      3'd1:    begin mac_byte = MAC_ADDR[39:32]; bc_byte = BCAST_MAC[39:32]; end
      3'd2:    begin mac_byte = MAC_ADDR[31:24]; bc_byte = BCAST_MAC[31:24]; end
      3'd3:    begin mac_byte = MAC_ADDR[23:16]; bc_byte = BCAST_MAC[23:16]; end
      3'd4:    begin mac_byte = MAC_ADDR[15:8];  bc_byte = BCAST_MAC[15:8];  end
      default: begin mac_byte = MAC_ADDR[7:0];   bc_byte = BCAST_MAC[7:0];   end
    endcase

    mac_ok_d = mac_ok_q;
    bc_ok_d  = bc_ok_q;
    if (en) begin
      // byte 0 restarts the match; later bytes must keep it alive
      mac_ok_d = (data == mac_byte) && ((idx == 3'd0) || mac_ok_q);
      bc_ok_d  = (data == bc_byte) && ((idx == 3'd0) || bc_ok_q);
    end
    hit = PROMISC || mac_ok_d || bc_ok_d;
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      mac_ok_q <= 1'b0;
      bc_ok_q  <= 1'b0;
    end else begin
      mac_ok_q <= mac_ok_d;
      bc_ok_q  <= bc_ok_d;
    end
  end

endmodule

// File: rtl/phy1_rcv.sv
// PHY1 receive path: preamble/SFD lock, destination filter, packet-buffer write,
// CRC32 residue check and a single-buffer valid/release handshake to the consumer.
//   state | meaning
//   SYNC  | after reset, wait for rx_dv low so we never lock mid-frame
//   IDLE  | waiting for the first preamble/SFD byte
//   PRE   | inside preamble, waiting for SFD
//   DATA  | writing frame bytes; frame is judged the cycle rx_dv falls
//   CHECK | one-cycle gap after the verdict
//   DROP  | discard until rx_dv falls
module phy1_rcv
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter bit          PROMISC  = 1'b0,
  parameter int          ADDR_W   = 11,
  parameter int          MIN_LEN  = 64,
  parameter int          MAX_LEN  = 1518
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic              rx_er,
  input  logic [7:0]        rx_data,
  output logic [ADDR_W-1:0] ipmem_address,
  output logic [7:0]        ipmem_data,
  output logic              ipmem_wren,
  output logic              frame_valid,
  output logic              frame_done,
  output logic [ADDR_W-1:0] frame_len,
  input  logic              buf_release,
  output logic [15:0]       good_cnt,
  output logic [15:0]       bad_cnt,
  output logic [15:0]       drop_cnt
);

  localparam logic [ADDR_W-1:0] MIN_L = ADDR_W'(MIN_LEN);
  localparam logic [ADDR_W-1:0] MAX_L = ADDR_W'(MAX_LEN);

  rcv_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       crc_q, crc_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] frame_len_q, frame_len_d;
  logic [15:0]       good_q, good_d;
  logic [15:0]       bad_q, bad_d;
  logic [15:0]       drop_q, drop_d;
  logic              filt_en, filt_hit;

  assign filt_en = (state_q == ST_DATA) && rx_dv && (cnt_q < ADDR_W'(6));

  eth_mac_filter #(
    .MAC_ADDR (MAC_ADDR),
    .PROMISC  (PROMISC)
  ) u_filter (
    .clock (clock),
    .rst   (rst),
    .en    (filt_en),
    .idx   (cnt_q[2:0]),
    .data  (rx_data),
    .hit   (filt_hit)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    crc_d         = crc_q;
    err_d         = err_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_valid_d = frame_valid_q & ~buf_release;
    frame_done_d  = 1'b0;
    frame_len_d   = frame_len_q;
    good_d        = good_q;
    bad_d         = bad_q;
    drop_d        = drop_q;

    case (state_q)
      ST_SYNC: if (!rx_dv) state_d = ST_IDLE;
      ST_IDLE: begin
        cnt_d = '0;
        crc_d = CRC_INIT;
        err_d = 1'b0;
        if (rx_dv) begin
          if (frame_valid_q) begin
            state_d = ST_DROP;
            drop_d  = sat_inc(drop_q);
          end else if (rx_data == PREAMBLE_BYTE) begin
            state_d = ST_PRE;
          end else if (rx_data == SFD_BYTE) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_DROP;
            drop_d  = sat_inc(drop_q);
          end
        end
      end
      ST_PRE: begin
        cnt_d = '0;
        crc_d = CRC_INIT;
        err_d = 1'b0;
        if (rx_dv && (rx_data == SFD_BYTE)) begin
          state_d = ST_DATA;
        end else if (!rx_dv || (rx_data != PREAMBLE_BYTE)) begin
          state_d = rx_dv ? ST_DROP : ST_IDLE;
          drop_d  = sat_inc(drop_q);
        end
      end
      ST_DATA: begin
        if (!rx_dv) begin
          state_d = ST_CHECK;
          if ((cnt_q >= MIN_L) && !err_q && (crc_q == CRC_RESIDUE)) begin
            frame_valid_d = 1'b1;
            frame_done_d  = 1'b1;
            frame_len_d   = cnt_q;
            good_d        = sat_inc(good_q);
          end else begin
            bad_d = sat_inc(bad_q);
          end
        end else if (cnt_q == MAX_L) begin
          state_d = ST_DROP;
          bad_d   = sat_inc(bad_q);
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = rx_data;
          cnt_d     = cnt_q + 1'b1;
          crc_d     = crc32_byte(crc_q, rx_data);
          err_d     = err_q | rx_er;
          if (filt_en && (cnt_q[2:0] == 3'd5) && !filt_hit) begin
            state_d = ST_DROP;
            drop_d  = sat_inc(drop_q);
          end
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      ST_DROP:  if (!rx_dv) state_d = ST_IDLE;
      default:  state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q       <= ST_SYNC;
      cnt_q         <= '0;
      crc_q         <= CRC_INIT;
      err_q         <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_len_q   <= '0;
      good_q        <= '0;
      bad_q         <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      crc_q         <= crc_d;
      err_q         <= err_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_valid_q <= frame_valid_d;
      frame_done_q  <= frame_done_d;
      frame_len_q   <= frame_len_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      drop_q        <= drop_d;
    end
  end

  assign ipmem_address = wr_addr_q;
  assign ipmem_data    = wr_data_q;
  assign ipmem_wren    = wr_en_q;
  assign frame_valid   = frame_valid_q;
  assign frame_done    = frame_done_q;
  assign frame_len     = frame_len_q;
  assign good_cnt      = good_q;
  assign bad_cnt       = bad_q;
  assign drop_cnt      = drop_q;

endmodule
